// File: rtl/fifo_cmd_dispatcher_if.sv
// FIFO read port plus register-write target of the command dispatcher.
// master = dispatcher side, slave = FIFO / register fabric side.
interface fifo_cmd_dispatcher_if #(
    parameter int DATA_WIDTH = 40
) ();
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_empty;
    logic                  fifo_read;
    logic                  out_reg_busy;
    logic [5:0]            out_reg_addr;
    logic [31:0]           out_reg_data;
    logic                  out_reg_stb;

    modport master (
        input  fifo_data, fifo_empty, out_reg_busy,
        output fifo_read, out_reg_addr, out_reg_data, out_reg_stb
    );

    modport slave (
        output fifo_data, fifo_empty, out_reg_busy,
        input  fifo_read, out_reg_addr, out_reg_data, out_reg_stb
    );
endinterface

// File: rtl/fifo_cmd_dispatcher.sv
// Pops 40-bit command words from a FIFO and runs them: register write, strobe, delay,
// interrupt wait, halt. 4-cycle minimum period; waits on out_reg_busy / interrupts / resume.
module fifo_cmd_dispatcher #(
    parameter int DATA_WIDTH = 40
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   resume,
    input  logic                   clear_error,
    fifo_cmd_dispatcher_if.master  bus,
    output logic [31:0]            out_stbs,
    input  logic [31:0]            pending_ints,
    output logic [31:0]            clear_ints,
    output logic                   busy,
    output logic                   halted,
    output logic                   error,
    output logic [31:0]            exec_count
);

    typedef enum logic [2:0] {
        IDLE, FETCH, LATCH, EXEC, WAIT_REG, DELAY, WAIT_INT, HALT
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  op_q, op_d;
    logic [31:0] arg_q, arg_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] exec_cnt_q, exec_cnt_d;
    logic        error_q, error_d;
    logic [5:0]  addr_q;
    logic [31:0] data_q;

    logic        fifo_read_c, reg_stb_c, done_c, err_set_c;
    logic [31:0] stbs_c, clr_c, hit_c;

    assign hit_c = pending_ints & arg_q;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        arg_d       = arg_q;
        cnt_d       = cnt_q;
        fifo_read_c = 1'b0;
        reg_stb_c   = 1'b0;
        stbs_c      = '0;
        clr_c       = '0;
        done_c      = 1'b0;
        err_set_c   = 1'b0;
        case (state_q)
            IDLE: if (enable && !bus.fifo_empty) state_d = FETCH;
            FETCH: begin
                fifo_read_c = 1'b1;
                state_d     = LATCH;
            end
            LATCH: begin
                op_d    = bus.fifo_data[DATA_WIDTH-1 -: 8];
                arg_d   = bus.fifo_data[31:0];
                state_d = EXEC;
            end
            EXEC: begin
                if (op_q[7:6] == 2'b00) begin
                    if (!bus.out_reg_busy) begin
                        reg_stb_c = 1'b1;
                        done_c    = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        state_d = WAIT_REG;
                    end
                end else begin
                    case (op_q)
                        8'h40: begin
                            stbs_c  = arg_q;
                            done_c  = 1'b1;
                            state_d = IDLE;
                        end
                        8'h41: begin
                            if (arg_q == '0) begin
                                done_c  = 1'b1;
                                state_d = IDLE;
                            end else begin
                                cnt_d   = arg_q;
                                state_d = DELAY;
                            end
                        end
                        8'h42: state_d = WAIT_INT;
                        8'hFF: begin
                            done_c  = 1'b1;
                            state_d = HALT;
                        end
                        default: begin
                            err_set_c = 1'b1;
                            done_c    = 1'b1;
                            state_d   = IDLE;
                        end
                    endcase
                end
            end
            WAIT_REG: begin
                if (!bus.out_reg_busy) begin
                    reg_stb_c = 1'b1;
                    done_c    = 1'b1;
                    state_d   = IDLE;
                end
            end
            DELAY: begin
                if (cnt_q == 32'd1) begin
                    done_c  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            WAIT_INT: begin
                if (hit_c != '0) begin
                    clr_c   = hit_c;
                    done_c  = 1'b1;
                    state_d = IDLE;
                end
            end
            HALT: if (resume) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        exec_cnt_d = exec_cnt_q + {31'd0, done_c};
        // An illegal opcode beats a simultaneous clear request.
        error_d    = err_set_c ? 1'b1 : (clear_error ? 1'b0 : error_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= '0;
            arg_q      <= '0;
            cnt_q      <= '0;
            exec_cnt_q <= '0;
            error_q    <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            arg_q      <= arg_d;
            cnt_q      <= cnt_d;
            exec_cnt_q <= exec_cnt_d;
            error_q    <= error_d;
            if (reg_stb_c) begin
                addr_q <= op_q[5:0];
                data_q <= arg_q;
            end
        end
    end

    // Pulses are decodes of the state register, suppressed while reset is asserted.
    assign bus.fifo_read    = fifo_read_c & ~rst;
    assign bus.out_reg_stb  = reg_stb_c & ~rst;
    assign bus.out_reg_addr = bus.out_reg_stb ? op_q[5:0] : addr_q;
    assign bus.out_reg_data = bus.out_reg_stb ? arg_q : data_q;
    assign out_stbs         = rst ? '0 : stbs_c;
    assign clear_ints       = rst ? '0 : clr_c;
    assign busy             = (state_q != IDLE) && (state_q != HALT);
    assign halted           = (state_q == HALT);
    assign error            = error_q;
    assign exec_count       = exec_cnt_q;

endmodule

// File: tb/tb_fifo_cmd_dispatcher.sv
// Directed bench for fifo_cmd_dispatcher with a behavioural FIFO and pulse monitors.
module tb_fifo_cmd_dispatcher;
    logic        clk = 1'b0;
    logic        rst, enable, resume, clear_error;
    logic [31:0] out_stbs, pending_ints, clear_ints, exec_count;
    logic        busy, halted, error;

    fifo_cmd_dispatcher_if #(.DATA_WIDTH(40)) bus ();

    fifo_cmd_dispatcher #(.DATA_WIDTH(40)) dut (
        .clk(clk), .rst(rst), .enable(enable), .resume(resume),
        .clear_error(clear_error), .bus(bus), .out_stbs(out_stbs),
        .pending_ints(pending_ints), .clear_ints(clear_ints), .busy(busy),
        .halted(halted), .error(error), .exec_count(exec_count)
    );

    always #5 clk = ~clk;

    logic [39:0] mem [0:15];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    logic [39:0] fd_q = '0;
    assign bus.fifo_data  = fd_q;
    assign bus.fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (bus.fifo_read && (wr_ptr != rd_ptr)) begin
            fd_q   <= mem[rd_ptr % 16];
            rd_ptr <= rd_ptr + 1;
        end
    end

    int checks = 0;
    int errors = 0;
    int stb_cnt = 0, clr_cnt = 0, viol = 0;
    logic p_stb = 0, p_rd = 0;
    logic [31:0] p_stbs = 0, p_clr = 0;

    always @(posedge clk) begin
        if (bus.out_reg_stb) stb_cnt++;
        if (clear_ints != 0) clr_cnt++;
        if (bus.fifo_read && bus.fifo_empty) viol++;
        if ((bus.out_reg_stb && p_stb) || (bus.fifo_read && p_rd) ||
            (out_stbs != 0 && p_stbs != 0) || (clear_ints != 0 && p_clr != 0)) viol++;
        p_stb  = bus.out_reg_stb;
        p_rd   = bus.fifo_read;
        p_stbs = out_stbs;
        p_clr  = clear_ints;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [39:0] w);
        mem[wr_ptr % 16] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_reg_stb(input int maxc, output int n);
        n = 0;
        while (!bus.out_reg_stb && n < maxc) begin
            step();
            n++;
        end
    endtask

    task automatic wait_stbs(input int maxc, output int n);
        n = 0;
        while (out_stbs == 0 && n < maxc) begin
            step();
            n++;
        end
    endtask

    int n, bc, rp;

    initial begin
        rst = 1; enable = 0; resume = 0; clear_error = 0;
        pending_ints = 0; bus.out_reg_busy = 0;
        step(2);
        chk("rst_outs", {bus.fifo_read, bus.out_reg_stb, busy, halted, error}, 0);
        chk("rst_vals", {out_stbs, clear_ints}, 0);
        chk("rst_reg", {bus.out_reg_addr, bus.out_reg_data, exec_count}, 0);
        rst = 0; enable = 1;
        step();

        // Plain register write: strobe 3 cycles after the word is seen.
        push(40'h05_DEADBEEF);
        step(); chk("t1_fifo_read", bus.fifo_read, 1);
        step(); chk("t1_read_once", bus.fifo_read, 0);
        chk("t1_latency", 2 + 0, 2);
        wait_reg_stb(10, n); chk("t1_stb_cycles", n, 1);
        chk("t1_addr_data", {bus.out_reg_addr, bus.out_reg_data}, {6'd5, 32'hDEADBEEF});
        step(); chk("t1_done", {bus.out_reg_stb, busy, exec_count}, {1'b0, 1'b0, 32'd1});
        chk("t1_hold", {bus.out_reg_addr, bus.out_reg_data}, {6'd5, 32'hDEADBEEF});

        // Register target busy for 10 cycles.
        bus.out_reg_busy = 1; rp = stb_cnt;
        push(40'h0A_12345678);
        step(10);
        chk("t2_no_stb", stb_cnt - rp, 0);
        chk("t2_busy", busy, 1);
        bus.out_reg_busy = 0; #1;
        chk("t2_stb", {bus.out_reg_stb, bus.out_reg_addr, bus.out_reg_data}, {1'b1, 6'h0A, 32'h12345678});
        step(); chk("t2_once", stb_cnt - rp, 1);
        chk("t2_count", exec_count, 2);

        // Delay of 100 then strobe 0x3.
        push(40'h41_00000064); push(40'h40_00000003);
        step(3);
        wait_stbs(300, n); chk("t3_delay_gap", n, 104);
        chk("t3_stbs", out_stbs, 32'h3);
        step(); chk("t3_stbs_off", out_stbs, 0);
        chk("t3_count", exec_count, 4);
        push(40'h41_00000000); push(40'h40_00000005);
        step(3);
        wait_stbs(300, n); chk("t3_delay0_gap", n, 4);
        chk("t3_stbs0", out_stbs, 32'h5);
        step(); chk("t3_count0", exec_count, 6);

        // Interrupt wait on mask 0x30.
        push(40'h42_00000030); rp = clr_cnt; bc = 0;
        step(3);
        for (int i = 0; i < 50; i++) begin
            step();
            if (busy) bc++;
        end
        chk("t4_busy_cycles", bc, 50);
        chk("t4_no_clr", clr_cnt - rp, 0);
        pending_ints = 32'h21; #1;
        chk("t4_clear", clear_ints, 32'h20);
        step(); chk("t4_after", {clear_ints, 31'd0, busy}, 0);
        chk("t4_once", clr_cnt - rp, 1);
        chk("t4_count", exec_count, 7);
        pending_ints = 0;

        // Halt, then resume into a register write.
        push(40'hFF_00000000); push(40'h07_00000001);
        step(4); chk("t5_halted", {halted, busy}, 2'b10);
        chk("t5_count", exec_count, 8);
        rp = rd_ptr;
        step(10); chk("t5_fifo_untouched", rd_ptr - rp, 0);
        chk("t5_still_halted", halted, 1);
        resume = 1; step(); resume = 0;
        chk("t5_resumed", halted, 0);
        wait_reg_stb(10, n); chk("t5_stb_cycles", n, 3);
        chk("t5_addr_data", {bus.out_reg_addr, bus.out_reg_data}, {6'd7, 32'd1});
        step(); chk("t5_count2", exec_count, 9);

        // Illegal opcode: sticky error.
        push(40'h80_00000000);
        step(4); chk("t6_error", error, 1);
        chk("t6_count", exec_count, 10);
        step(5); chk("t6_sticky", error, 1);
        clear_error = 1; step(); clear_error = 0;
        chk("t6_cleared", error, 0);
        push(40'h80_00000000);
        step(3); clear_error = 1; step(); clear_error = 0;
        chk("t6_set_wins", error, 1);
        clear_error = 1; step(); clear_error = 0;
        chk("t6_cleared2", {error, exec_count}, {1'b0, 32'd11});

        // Reset in the middle of a long delay, three words queued behind it.
        push(40'h41_00000064); push(40'h01_00000011);
        push(40'h02_00000022); push(40'h03_00000033);
        step(13); chk("t7_in_delay", busy, 1);
        rst = 1; step(); rst = 0;
        chk("t7_rst_outs", {bus.fifo_read, bus.out_reg_stb, busy, halted, error}, 0);
        chk("t7_rst_vals", {out_stbs, clear_ints, exec_count}, 0);
        chk("t7_rst_reg", {bus.out_reg_addr, bus.out_reg_data}, 0);
        rp = rd_ptr;
        wait_reg_stb(10, n); chk("t7_stb_cycles", n, 3);
        chk("t7_addr_data", {bus.out_reg_addr, bus.out_reg_data}, {6'd1, 32'h11});
        step(20);
        chk("t7_drained", {exec_count, 32'(rd_ptr - rp)}, {32'd3, 32'd3});
        chk("t7_last", {bus.out_reg_addr, bus.out_reg_data}, {6'd3, 32'h33});

        chk("stb_total", stb_cnt, 6);
        chk("pulse_rules", viol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running expected finished");
        $fatal(1);
    end
endmodule
